i2c_slave_target: RTL and testbench

- Clock-oversampled I2C target that sits directly downstream of i2c_master on the same scl/sda bus pair.
- Decodes START, STOP and repeated START, matches a 7-bit address and ACKs it.
- Write transfers: shifts in bytes and presents them to a local consumer.
- Read transfers: fetches bytes from a local producer and shifts them out MSB-first.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 73 +++++++
 rtl/i2c_slave_target.sv | 176 +++++++++++++++++
 tb/tb_i2c_slave_target.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target.
//   i2c_state_t : target FSM states
//   I2C_ADDR_W  : bus address width
//   I2C_ACK / I2C_NACK : acknowledge bit levels on sda
package i2c_pkg;

    localparam int       I2C_ADDR_W = 7;
    localparam logic     I2C_ACK    = 1'b0;
    localparam logic     I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-flop synchronizer for one bus line, optional glitch
// filter, and single-cycle rise/fall pulses of the conditioned level.
// Optional filter enabled by macro I2C_SLAVE_GLITCH_FILTER_EN.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   line     : raw asynchronous bus line
//   lvl      : conditioned line level
//   rise/fall: one-cycle pulses on lvl edges
module i2c_line_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic lvl,
    output logic rise,
    output logic fall
);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif
    localparam int EFF_LEN = FILT_EN ? FILT_LEN : 0;

    logic s1, s2, prev;

    // Reset to 1 (idle bus level) so leaving reset does not fake an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= line;
            s2 <= s1;
        end
    end

    generate
        if (EFF_LEN > 0) begin : g_filt
            localparam int CW = $clog2(EFF_LEN + 1);
            logic [CW-1:0] cnt;
            logic          filt;
            // Output flips only after EFF_LEN consecutive differing samples.
            always_ff @(posedge clk) begin
                if (rst) begin
                    filt <= 1'b1;
                    cnt  <= '0;
                end else if (s2 == filt) begin
                    cnt  <= '0;
                end else if (cnt == CW'(EFF_LEN - 1)) begin
                    filt <= s2;
                    cnt  <= '0;
                end else begin
                    cnt  <= cnt + 1'b1;
                end
            end
            assign lvl = filt;
        end else begin : g_nofilt
            assign lvl = s2;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= lvl;
    end

    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;

endmodule

// File: rtl/i2c_slave_target.sv
// i2c_slave_target: clock-oversampled I2C target. Decodes START/STOP/
// repeated START, ACKs SLAVE_ADDR, delivers write bytes on rx_data/rx_valid
// and serves read bytes fetched from tx_data on tx_req.
// Optional glitch filter on scl/sda: macro I2C_SLAVE_GLITCH_FILTER_EN.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   scl        : bus clock from master
//   sda        : open-drain data (driven 0 or z only)
//   tx_data    : read byte, sampled in the cycle tx_req is raised
//   tx_req     : one-cycle fetch pulse
//   rx_data    : last write byte, rx_valid pulses on update
//   busy       : addressed transfer in progress
//   addr_match : current transfer targets SLAVE_ADDR
//   rw_dir     : R/W bit of current transfer (1 = read)
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'b1011001,
    parameter int                    FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       addr_match,
    output logic       rw_dir
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_scl_sync (
        .clk(clk), .rst(rst), .line(scl),
        .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_sync #(.FILT_LEN(FILT_LEN)) u_sda_sync (
        .clk(clk), .rst(rst), .line(sda),
        .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    wire start_det = sda_fall & scl_lvl;
    wire stop_det  = sda_rise & scl_lvl;

    i2c_state_t state;
    logic [7:0] shreg;
    logic [3:0] bitcnt;
    logic       sda_oe;
    // ACK sub-phase: in ADDR_ACK/WR_ACK marks the drive-low half;
    // in RD_ACK marks that the master acknowledged.
    logic       ack_on;

    // Release is combinational with rst so the line frees the same cycle.
    assign sda = (sda_oe && !rst) ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        tx_req   <= 1'b0;
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            sda_oe     <= 1'b0;
            ack_on     <= 1'b0;
            rx_data    <= '0;
            busy       <= 1'b0;
            addr_match <= 1'b0;
            rw_dir     <= 1'b0;
        end else if (start_det) begin
            // Also the repeated-START path: busy/addr_match persist until
            // the new address byte is judged.
            state  <= ADDR;
            shreg  <= '0;
            bitcnt <= '0;
            sda_oe <= 1'b0;
            ack_on <= 1'b0;
        end else if (stop_det) begin
            state      <= IDLE;
            bitcnt     <= '0;
            sda_oe     <= 1'b0;
            ack_on     <= 1'b0;
            busy       <= 1'b0;
            addr_match <= 1'b0;
            rw_dir     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR: begin
                    if (bitcnt == 4'd8) begin
                        bitcnt <= '0;
                        if (shreg[7 -: I2C_ADDR_W] == SLAVE_ADDR) begin
                            addr_match <= 1'b1;
                            busy       <= 1'b1;
                            rw_dir     <= shreg[0];
                            state      <= ADDR_ACK;
                        end else begin
                            addr_match <= 1'b0;
                            busy       <= 1'b0;
                            rw_dir     <= 1'b0;
                            state      <= WAIT_STOP;
                        end
                    end else if (scl_rise) begin
                        shreg  <= {shreg[6:0], sda_lvl};
                        bitcnt <= bitcnt + 4'd1;
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on) begin
                            ack_on <= 1'b1;
                            sda_oe <= 1'b1;
                        end else begin
                            ack_on <= 1'b0;
                            if (state == ADDR_ACK && rw_dir) begin
                                tx_req <= 1'b1;
                                shreg  <= tx_data;
                                sda_oe <= ~tx_data[7];
                                bitcnt <= 4'd1;
                                state  <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (bitcnt == 4'd8) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                        bitcnt   <= '0;
                        state    <= WR_ACK;
                    end else if (scl_rise) begin
                        shreg  <= {shreg[6:0], sda_lvl};
                        bitcnt <= bitcnt + 4'd1;
                    end
                end
                RD_DATA: begin
                    // bitcnt = number of bits already placed on sda
                    if (scl_fall) begin
                        if (bitcnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            bitcnt <= '0;
                            state  <= RD_ACK;
                        end else begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                            bitcnt <= bitcnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_ACK) ack_on <= 1'b1;
                        else                    state  <= WAIT_STOP;
                    end else if (scl_fall && ack_on) begin
                        ack_on <= 1'b0;
                        tx_req <= 1'b1;
                        shreg  <= tx_data;
                        sda_oe <= ~tx_data[7];
                        bitcnt <= 4'd1;
                        state  <= RD_DATA;
                    end
                end
                WAIT_STOP: sda_oe <= 1'b0;
                default:   state  <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_target.sv
// tb_i2c_slave_target: directed bench acting as the I2C master.
module tb_i2c_slave_target;
    import i2c_pkg::*;

    localparam int         H    = 12;            // clk cycles per scl half
    localparam logic [6:0] ADR  = 7'b1011001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_drv = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic       tx_req, rx_valid, busy, addr_match, rw_dir;
    logic [7:0] rx_data;

    assign sda = m_drv ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_target #(.SLAVE_ADDR(ADR), .FILT_LEN(3)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .tx_data(tx_data),
        .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .addr_match(addr_match), .rw_dir(rw_dir)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int rx_cnt = 0, tx_cnt = 0, tgt_low = 0, nbusy = 0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_cnt++;
        if (tx_req === 1'b1)   tx_cnt++;
        if (sda === 1'b0 && !m_drv) tgt_low++;
        if (busy !== 1'b1) nbusy++;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(3); m_drv = !b; wait_clk(H - 3);
        scl = 1'b1; wait_clk(H); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(3); m_drv = 1'b0; wait_clk(H - 3);
        scl = 1'b1; wait_clk(H / 2); b = sda; wait_clk(H - H / 2); scl = 1'b0;
    endtask

    task automatic i2c_start;
        wait_clk(3); m_drv = 1'b0; wait_clk(H);
        scl = 1'b1; wait_clk(H); m_drv = 1'b1; wait_clk(H); scl = 1'b0;
    endtask

    task automatic i2c_stop;
        wait_clk(3); m_drv = 1'b1; wait_clk(H);
        scl = 1'b1; wait_clk(H); m_drv = 1'b0; wait_clk(H);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_bits(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clk(4);
        n_checks++;
        if ({tx_req, rx_valid, busy, addr_match, rw_dir, rx_data} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {tx_req, rx_valid, busy, addr_match, rw_dir, rx_data});
        end
        n_checks++;
        if (sda !== 1'b1) begin
            n_fail++; $display("FAIL reset_sda: got %b want 1 (released)", sda);
        end
        rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_write;
        logic a1, a2;
        int r0, l0;
        r0 = rx_cnt;
        i2c_start();
        l0 = tgt_low;
        send_byte({ADR, 1'b0}, a1);
        n_checks++;
        if (a1 !== I2C_ACK) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 0", a1); end
        n_checks++;
        if ({busy, addr_match, rw_dir} !== 3'b110) begin
            n_fail++; $display("FAIL wr_flags: got %b want 110", {busy, addr_match, rw_dir});
        end
        send_byte(8'hA5, a2);
        n_checks++;
        if (a2 !== I2C_ACK) begin n_fail++; $display("FAIL wr_data_ack: got %b want 0", a2); end
        n_checks++;
        if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL wr_rx_data: got %h want a5", rx_data); end
        n_checks++;
        if (rx_cnt - r0 != 1) begin n_fail++; $display("FAIL wr_rx_valid_cnt: got %0d want 1", rx_cnt - r0); end
        n_checks++;
        if (tgt_low == l0) begin n_fail++; $display("FAIL wr_target_drove: got 0 low cycles want >0"); end
        i2c_stop();
        n_checks++;
        if ({busy, addr_match} !== 2'b00) begin
            n_fail++; $display("FAIL wr_after_stop: got %b want 00", {busy, addr_match});
        end
    endtask

    task automatic test_mismatch;
        logic a;
        int r0, t0, l0;
        r0 = rx_cnt; t0 = tx_cnt;
        i2c_start();
        l0 = tgt_low;
        send_byte({7'b1011000, 1'b0}, a);
        n_checks++;
        if (a !== I2C_NACK) begin n_fail++; $display("FAIL mm_addr_nack: got %b want 1", a); end
        n_checks++;
        if (dut.state !== WAIT_STOP) begin n_fail++; $display("FAIL mm_state: got %0d want %0d", dut.state, WAIT_STOP); end
        send_byte(8'h55, a);
        n_checks++;
        if (a !== I2C_NACK) begin n_fail++; $display("FAIL mm_data_nack: got %b want 1", a); end
        n_checks++;
        if ({busy, addr_match} !== 2'b00) begin
            n_fail++; $display("FAIL mm_flags: got %b want 00", {busy, addr_match});
        end
        n_checks++;
        if (rx_cnt != r0 || tx_cnt != t0 || tgt_low != l0) begin
            n_fail++; $display("FAIL mm_activity: rx %0d tx %0d low %0d want 0 0 0",
                               rx_cnt - r0, tx_cnt - t0, tgt_low - l0);
        end
        n_checks++;
        if (dut.state !== WAIT_STOP) begin n_fail++; $display("FAIL mm_state_hold: got %0d want %0d", dut.state, WAIT_STOP); end
        i2c_stop();
        n_checks++;
        if (dut.state !== IDLE) begin n_fail++; $display("FAIL mm_state_stop: got %0d want %0d", dut.state, IDLE); end
    endtask

    task automatic test_read;
        logic a;
        logic [7:0] b1, b2;
        int t0, l0;
        tx_data = 8'h5A;
        t0 = tx_cnt;
        i2c_start();
        send_byte({ADR, 1'b1}, a);
        n_checks++;
        if (a !== I2C_ACK) begin n_fail++; $display("FAIL rd_addr_ack: got %b want 0", a); end
        n_checks++;
        if ({busy, addr_match, rw_dir} !== 3'b111) begin
            n_fail++; $display("FAIL rd_flags: got %b want 111", {busy, addr_match, rw_dir});
        end
        recv_bits(b1);
        tx_data = 8'h3C;
        send_bit(I2C_ACK);
        recv_bits(b2);
        send_bit(I2C_NACK);
        n_checks++;
        if (b1 !== 8'h5A) begin n_fail++; $display("FAIL rd_byte1: got %h want 5a", b1); end
        n_checks++;
        if (b2 !== 8'h3C) begin n_fail++; $display("FAIL rd_byte2: got %h want 3c", b2); end
        n_checks++;
        if (tx_cnt - t0 != 2) begin n_fail++; $display("FAIL rd_tx_req_cnt: got %0d want 2", tx_cnt - t0); end
        l0 = tgt_low;
        wait_clk(H);
        n_checks++;
        if (sda !== 1'b1 || tgt_low != l0) begin
            n_fail++; $display("FAIL rd_release_after_nack: sda %b low %0d want 1 0", sda, tgt_low - l0);
        end
        i2c_stop();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic a;
        logic [7:0] b;
        int nb0;
        i2c_start();
        send_byte({ADR, 1'b0}, a);
        send_byte(8'h11, a);
        n_checks++;
        if (rx_data !== 8'h11 || rw_dir !== 1'b0) begin
            n_fail++; $display("FAIL rs_write: rx %h rw %b want 11 0", rx_data, rw_dir);
        end
        nb0 = nbusy;
        tx_data = 8'hC3;
        i2c_start();
        send_byte({ADR, 1'b1}, a);
        n_checks++;
        if (a !== I2C_ACK || rw_dir !== 1'b1) begin
            n_fail++; $display("FAIL rs_read_addr: ack %b rw %b want 0 1", a, rw_dir);
        end
        recv_bits(b);
        send_bit(I2C_NACK);
        n_checks++;
        if (b !== 8'hC3) begin n_fail++; $display("FAIL rs_read_byte: got %h want c3", b); end
        n_checks++;
        if (nbusy != nb0) begin n_fail++; $display("FAIL rs_busy_held: dropped %0d cycles want 0", nbusy - nb0); end
        i2c_stop();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rs_busy_stop: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        logic a;
        i2c_start();
        send_byte({ADR, 1'b0}, a);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before: got %b want 1", busy); end
        wait_clk(3); m_drv = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_checks++;
        if ({tx_req, rx_valid, busy, addr_match, rw_dir, rx_data} !== 13'h0) begin
            n_fail++; $display("FAIL rm_outputs: got %h want 0",
                               {tx_req, rx_valid, busy, addr_match, rw_dir, rx_data});
        end
        n_checks++;
        if (sda !== 1'b1 || dut.state !== IDLE) begin
            n_fail++; $display("FAIL rm_sda_state: sda %b state %0d want 1 %0d", sda, dut.state, IDLE);
        end
        wait_clk(H);
        i2c_stop();
        i2c_start();
        send_byte({ADR, 1'b0}, a);
        n_checks++;
        if (a !== I2C_ACK) begin n_fail++; $display("FAIL rm_readdr_ack: got %b want 0", a); end
        send_byte(8'h3C, a);
        n_checks++;
        if (a !== I2C_ACK || rx_data !== 8'h3C) begin
            n_fail++; $display("FAIL rm_rewrite: ack %b rx %h want 0 3c", a, rx_data);
        end
        i2c_stop();
    endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    task automatic send_bit_glitch(input logic b, input int glen);
        wait_clk(3); m_drv = !b; wait_clk(H - 3);
        scl = 1'b1; wait_clk(6); scl = 1'b0; wait_clk(glen);
        scl = 1'b1; wait_clk(8); scl = 1'b0;
    endtask

    task automatic test_glitch_filter;
        logic a;
        logic [7:0] d;
        i2c_start();
        send_byte({ADR, 1'b0}, a);
        // 2-cycle scl dip inside bit 7: filtered away, byte arrives intact
        d = 8'hA5;
        send_bit_glitch(d[7], 2);
        for (int i = 6; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        n_checks++;
        if (a !== I2C_ACK || rx_data !== 8'hA5) begin
            n_fail++; $display("FAIL gf_short: ack %b rx %h want 0 a5", a, rx_data);
        end
        // 4-cycle dip is a real clock: bit 7 sampled twice, 7 master bits fill the byte
        send_bit_glitch(d[7], 4);
        for (int i = 6; i >= 1; i--) send_bit(d[i]);
        recv_bit(a);
        n_checks++;
        if (a !== I2C_ACK || rx_data !== 8'hD2) begin
            n_fail++; $display("FAIL gf_long: ack %b rx %h want 0 d2", a, rx_data);
        end
        i2c_stop();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        test_glitch_filter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
